// File: rtl/ps2_kbd.sv
// ps2_kbd: PS/2 keyboard receiver with a Wishbone slave front end.
// Conditions the raw PS/2 lines, deframes 11-bit device-to-host frames,
// checks odd parity and the stop bit, and queues good scan codes in a FIFO.
//
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   bus_adr..bus_ack    32-bit Wishbone slave (adr[2] selects DATA/STATUS)
//   ps2_clk, ps2_dat    raw asynchronous PS/2 lines
//   interrupt           registered level interrupt (irq_en & FIFO non-empty)
//
// Receiver FSM:
//   state | meaning
//   IDLE  | waiting for a falling edge with data low (start bit)
//   RECV  | shifting in 8 data bits, parity and stop; gap timer running
//   CHECK | one cycle: push the byte if parity/stop are good, else flag error
module ps2_kbd #(
    parameter int CLKFREQ     = 10000000,
    parameter int FIFO_AWIDTH = 4,
    parameter int FILTER      = 8,
    parameter int TIMEOUT_US  = 200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] bus_adr,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] bus_dat_o,
    input  logic        bus_we,
    input  logic [3:0]  bus_sel,
    input  logic        bus_cyc,
    input  logic        bus_stb,
    output logic        bus_ack,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        interrupt
);

    localparam int DEPTH = 1 << FIFO_AWIDTH;
    localparam int TCYC  = CLKFREQ / 1000000 * TIMEOUT_US;
    localparam int TW    = $clog2(TCYC + 1);
    localparam int FW    = $clog2(FILTER + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]             clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic                   clk_filt, fall;
    logic [FW-1:0]          filt_cnt;
    state_t                 state, state_nxt;
    logic [9:0]             shreg;
    logic [3:0]             bitcnt;
    logic [TW-1:0]          timer;
    logic                   push, err_set, timeout, frame_good;
    logic [7:0]             mem [DEPTH];
    logic [FIFO_AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AWIDTH:0]   count;
    logic                   empty, full, pop, do_push, do_pop, ovf_set;
    logic                   accept, sel_status, status_wr;
    logic                   irq_en, overflow, frame_err;
    logic [31:0]            rd_data;
    logic                   unused;

    assign unused = ^{bus_adr[31:3], bus_adr[1:0], bus_sel,
                      bus_dat_i[30:18], bus_dat_i[15:0]};

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // The filtered clock follows the synchronised clock only after FILTER
    // consecutive samples disagree with it; fall pulses on the 1->0 switch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER - 1)) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Bits arrive LSB first; after 10 shifts shreg = {stop, parity, data}.
    assign frame_good = (^shreg[8:0]) && shreg[9];
    assign timeout    = (state == RECV) && !fall && (timer == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE:  if (fall && !dat_s) state_nxt = RECV;
            RECV: begin
                if (fall && bitcnt == 4'd9) begin
                    state_nxt = CHECK;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (frame_good) push    = 1'b1;
                else            err_set = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gap timer counts down from TCYC-1, reloaded on every falling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg  <= '0;
            bitcnt <= '0;
            timer  <= '0;
        end else if (fall) begin
            timer <= TW'(TCYC - 1);
            if (state == IDLE) begin
                bitcnt <= '0;
            end else if (state == RECV) begin
                shreg  <= {dat_s, shreg[9:1]};
                bitcnt <= bitcnt + 1'b1;
            end
        end else if (state == RECV && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_AWIDTH + 1)'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= shreg[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign accept     = bus_cyc && bus_stb && !bus_ack;
    assign sel_status = bus_adr[2];
    assign pop        = accept && !bus_we && !sel_status;
    assign status_wr  = accept && bus_we && sel_status;

    always_comb begin
        rd_data = '0;
        if (sel_status) begin
            rd_data[FIFO_AWIDTH:0] = count;
            rd_data[8]             = empty;
            rd_data[9]             = full;
            rd_data[16]            = overflow;
            rd_data[17]            = frame_err;
            rd_data[31]            = irq_en;
        end else if (!empty) begin
            rd_data[8:0] = {1'b1, mem[rd_ptr]};
        end
    end

    // Set events win over a same-cycle write-1-to-clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_ack   <= 1'b0;
            bus_dat_o <= '0;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            bus_ack <= accept;
            if (accept)    bus_dat_o <= rd_data;
            if (status_wr) irq_en    <= bus_dat_i[31];
            overflow  <= ovf_set || (overflow && !(status_wr && bus_dat_i[16]));
            frame_err <= err_set || (frame_err && !(status_wr && bus_dat_i[17]));
            interrupt <= irq_en && !empty;
        end
    end

endmodule
